char_writer: RTL and testbench
==============================

CHAR_WRITER -- requirements
Module: char_writer

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 24, text rows on screen; COLS*ROWS SHALL be at most 2048.
REQ-003 pclk  in  1  single clock for all logic; same clock as the character buffer write port.
REQ-004 clr  in  1  reset, asynchronous, active-high.
REQ-005 in_data  in  8  incoming byte (ASCII) from the host/UART stage.
REQ-006 in_valid  in  1  in_data is valid.
REQ-007 in_ready  out  1  block can accept a byte; a byte transfers on a pclk edge where in_valid and in_ready are both 1.
REQ-008 buffer_addr  out  11  character buffer write address.
REQ-009 buffer_din  out  8  character code to write.
REQ-010 buffer_wen  out  1  write strobe, one pclk per write.
REQ-011 cursor_x  out  7  cursor column, 0..COLS-1.
REQ-012 cursor_y  out  5  cursor row on screen, 0..ROWS-1.
REQ-013 first_row  out  5  buffer row shown at screen top, consumed by the display stage for hardware scrolling.

Function
REQ-014 States: IDLE, LINE_CLEAR, plus RESET_CLEAR when CLEAR_ON_RESET_EN is defined; in_ready SHALL be 1 only in IDLE.
REQ-015 Physical row SHALL be pr = first_row+cursor_y, minus ROWS if the sum >= ROWS; the write address SHALL be pr*COLS+cursor_x.
REQ-016 Printable byte 0x20..0x7E: on the edge after acceptance, buffer_wen=1 for one cycle with the address taken from the pre-update cursor; cursor_x SHALL increment unless it equals COLS-1, in which case it holds (no autowrap).
REQ-017 0x0D (CR): cursor_x<=0, no write.
REQ-018 0x08 (BS): cursor_x<=cursor_x-1 if it is nonzero, else hold; no write.
REQ-019 0x09 (TAB): cursor_x<=next multiple of 8, clamped to COLS-1; no write.
REQ-020 0x0A (LF) with cursor_y<ROWS-1: cursor_y increments, no write.
REQ-021 0x0A with cursor_y==ROWS-1: first_row increments, wrapping ROWS-1->0, and cursor_y holds.
REQ-022 After the REQ-021 update, the block SHALL enter LINE_CLEAR and write 0x20 to all COLS cells of the new bottom physical row, one per cycle, in column order 0..COLS-1; it SHALL then return to IDLE.
REQ-023 All other bytes SHALL be consumed with no effect.
REQ-024 Back-to-back printable bytes SHALL sustain one byte per cycle in IDLE.
REQ-025 Bytes presented while in_ready=0 SHALL NOT be consumed and SHALL be held by the sender.

Reset
REQ-026 clr SHALL force: cursor_x=0, cursor_y=0, first_row=0, buffer_wen=0, buffer_addr=0, buffer_din=0.
REQ-027 After clr, in_ready=1 and state=IDLE when CLEAR_ON_RESET_EN is undefined.
REQ-028 clr asserted during LINE_CLEAR or RESET_CLEAR SHALL abort the clear immediately; the sequence SHALL restart from REQ-026/REQ-030.

Configuration
REQ-029 Macro CLEAR_ON_RESET_EN.
REQ-030 Defined: after clr deasserts, state RESET_CLEAR SHALL write 0x20 to addresses 0..COLS*ROWS-1 ascending, one per cycle, with in_ready=0; it SHALL then enter IDLE.
REQ-031 Undefined: no RESET_CLEAR state; buffer contents after reset are unspecified.

Structure
REQ-032 Shared package term_pkg SHALL hold the COLS/ROWS defaults and the character constants CR, LF, BS, TAB, SPACE; the display stage SHALL use the same package.
REQ-033 Sub-module line_clearer SHALL contain the clear-address counter (start address, count, busy/done) and SHALL be used by both LINE_CLEAR and RESET_CLEAR.

Verification
REQ-034 Reset, then send "AB" back-to-back: writes 0x41@0 and 0x42@1 on consecutive cycles; cursor_x=2.
REQ-035 Send 81 printable bytes on row 0: the last write lands at address 79 twice; cursor_x=79.
REQ-036 From cursor (10,5), send CR, LF, BS: cursor (0,6), BS holds cursor_x at 0, buffer_wen never asserted.
REQ-037 At cursor_y=23 with first_row=0, send LF: first_row=1; 80 writes of 0x20 to addresses 0..79; in_ready low 80 cycles; next printable byte writes to address 0+cursor_x.
REQ-038 With first_row=23 at cursor_y=23, send LF: first_row wraps to 0 and the clear targets addresses 1840..1919.
REQ-039 CLEAR_ON_RESET_EN defined: exactly 1920 writes of 0x20 to addresses 0..1919, then in_ready=1; clr pulsed at write 500 restarts the clear from address 0.

Source files
------------

// File: rtl/term_pkg.sv
// term_pkg: shared text-terminal geometry defaults, character codes and writer state type.
// Writer states include RESET_CLEAR only when CLEAR_ON_RESET_EN is defined.
package term_pkg;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 24;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] TAB   = 8'h09;
  localparam logic [7:0] SPACE = 8'h20;
`ifdef CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {IDLE, LINE_CLEAR, RESET_CLEAR} state_t;
`else
  typedef enum logic {IDLE, LINE_CLEAR} state_t;
`endif
  function automatic logic is_print(input logic [7:0] c);
    return c >= 8'h20 && c <= 8'h7E;
  endfunction
endpackage

// File: rtl/char_writer_line_clearer.sv
// line_clearer: walks i_count consecutive buffer addresses from i_start_addr, one per cycle.
module line_clearer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [10:0] i_start_addr,
  input  logic [11:0] i_count,
  output logic        o_busy,
  output logic        o_last,
  output logic [10:0] o_addr
);
  logic        r_busy;
  logic [10:0] r_addr;
  logic [11:0] r_left;
  assign o_busy = r_busy;
  assign o_addr = r_addr;
  assign o_last = r_busy && r_left == 12'd1;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_busy <= 1'b0;
      r_addr <= '0;
      r_left <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_addr <= i_start_addr;
      r_left <= i_count;
    end else if (r_busy) begin
      r_busy <= !o_last;
      r_addr <= r_addr + 11'd1;
      r_left <= r_left - 12'd1;
    end
endmodule

// File: rtl/char_writer.sv
// char_writer: turns a byte stream into character-buffer writes with cursor control and hardware scrolling.
// Define CLEAR_ON_RESET_EN to blank the whole buffer after every reset.
module char_writer
  import term_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        pclk,
  input  logic        clr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] buffer_addr,
  output logic [7:0]  buffer_din,
  output logic        buffer_wen,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [4:0]  first_row
);
  state_t      r_state, w_next;
  logic [6:0]  r_cx, w_cx;
  logic [4:0]  r_cy, r_fr, w_pr;
  logic        r_wen;
  logic [10:0] r_addr, w_addr, w_start_addr, w_clr_addr;
  logic [7:0]  r_din, w_tab8;
  logic [6:0]  w_tab;
  logic [5:0]  w_sum;
  logic [11:0] w_count;
  logic        w_acc, w_print, w_scroll, w_start, w_clr_busy, w_clr_last;

  assign in_ready = r_state == IDLE;
  assign w_acc    = in_valid && in_ready;
  assign w_print  = is_print(in_data);
  assign w_scroll = w_acc && in_data == LF && r_cy == 5'(ROWS - 1);
  assign w_sum    = {1'b0, r_fr} + {1'b0, r_cy};
  assign w_pr     = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];
  assign w_addr   = w_pr * 11'(COLS) + {4'b0, r_cx};
  assign w_tab8   = {5'(r_cx[6:3]) + 5'd1, 3'b000};
  assign w_tab    = (w_tab8 > 8'(COLS - 1)) ? 7'(COLS - 1) : w_tab8[6:0];
  assign w_cx     = w_print ? ((r_cx == 7'(COLS - 1)) ? r_cx : r_cx + 7'd1) :
                    in_data == CR  ? 7'd0 :
                    in_data == BS  ? ((r_cx != 7'd0) ? r_cx - 7'd1 : r_cx) :
                    in_data == TAB ? w_tab : r_cx;

  // After a scroll the new bottom row is the physical row that used to be at the top.
  assign w_start_addr = (r_state == IDLE) ? r_fr * 11'(COLS) : 11'd0;
  assign w_count      = (r_state == IDLE) ? 12'(COLS) : 12'(COLS * ROWS);
`ifdef CLEAR_ON_RESET_EN
  assign w_start = w_scroll || (r_state == RESET_CLEAR && !w_clr_busy);
`else
  assign w_start = w_scroll;
`endif

  line_clearer u_clearer (
    .i_clk       (pclk),
    .i_rst       (clr),
    .i_start     (w_start),
    .i_start_addr(w_start_addr),
    .i_count     (w_count),
    .o_busy      (w_clr_busy),
    .o_last      (w_clr_last),
    .o_addr      (w_clr_addr)
  );

  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_scroll) w_next = LINE_CLEAR;
    else if (r_state != IDLE && w_clr_last) w_next = IDLE;
  end

  always_ff @(posedge pclk or posedge clr)
    if (clr) begin
`ifdef CLEAR_ON_RESET_EN
      r_state <= RESET_CLEAR;
`else
      r_state <= IDLE;
`endif
      r_cx   <= '0;
      r_cy   <= '0;
      r_fr   <= '0;
      r_wen  <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_state <= w_next;
      r_wen   <= w_acc && w_print;
      if (w_acc && w_print) begin
        r_addr <= w_addr;
        r_din  <= in_data;
      end
      if (w_acc) r_cx <= w_cx;
      if (w_acc && in_data == LF && !w_scroll) r_cy <= r_cy + 5'd1;
      if (w_scroll) r_fr <= (r_fr == 5'(ROWS - 1)) ? 5'd0 : r_fr + 5'd1;
    end

  assign buffer_wen  = (r_state == IDLE) ? r_wen  : w_clr_busy;
  assign buffer_addr = (r_state == IDLE) ? r_addr : w_clr_addr;
  assign buffer_din  = (r_state == IDLE) ? r_din  : SPACE;
  assign cursor_x    = r_cx;
  assign cursor_y    = r_cy;
  assign first_row   = r_fr;
endmodule

// File: tb/tb_char_writer.sv
// tb_char_writer: scoreboard bench for char_writer with a screen-level reference model.
module tb_char_writer;
  localparam int COLS = 80;
  localparam int ROWS = 24;
  typedef struct packed {logic [10:0] a; logic [7:0] d;} wr_t;

  logic        pclk = 1'b0, clr = 1'b1, in_valid = 1'b0, in_ready, buffer_wen;
  logic [7:0]  in_data = 8'h00, buffer_din;
  logic [10:0] buffer_addr;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y, first_row;

  int  checks = 0, errors = 0, cyc = 0, wr_cnt = 0, last_wr = -10, prev_wr = -10;
  int  mx, my, mf;
  wr_t q[$];
  wr_t e;

  char_writer dut (
    .pclk(pclk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .buffer_addr(buffer_addr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .first_row(first_row)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Screen-level model: writes land at ((first_row+y) mod ROWS)*COLS + x.
  task automatic apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      q.push_back('{11'(((mf + my) % ROWS) * COLS + mx), b});
      if (mx < COLS - 1) mx++;
    end else if (b == 8'h0D) mx = 0;
    else if (b == 8'h08) begin
      if (mx > 0) mx--;
    end else if (b == 8'h09) mx = ((mx / 8 + 1) * 8 > COLS - 1) ? COLS - 1 : (mx / 8 + 1) * 8;
    else if (b == 8'h0A) begin
      if (my < ROWS - 1) my++;
      else begin
        mf = (mf + 1) % ROWS;
        for (int i = 0; i < COLS; i++) q.push_back('{11'(((mf + ROWS - 1) % ROWS) * COLS + i), 8'h20});
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 3000) begin tick(1); n++; end
    if (!in_ready) check(name, in_ready, 1);
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    wait_ready("ready_timeout");
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(posedge pclk);
    apply(b);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_cursor();
    check("cursor_x", cursor_x, mx);
    check("cursor_y", cursor_y, my);
    check("first_row", first_row, mf);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr = 1'b1;
    tick(2);
    q.delete();
    mx = 0; my = 0; mf = 0;
    check_cursor();
    check("rst_wen", buffer_wen, 0);
    check("rst_addr", buffer_addr, 0);
    check("rst_din", buffer_din, 0);
    clr = 1'b0;
`ifdef CLEAR_ON_RESET_EN
    for (int i = 0; i < COLS * ROWS; i++) q.push_back('{11'(i), 8'h20});
    tick(1);
    check("ready_during_reset_clear", in_ready, 0);
    wait_ready("reset_clear_timeout");
    tick(1);
    check("reset_clear_drained", q.size(), 0);
`else
    tick(1);
    check("rst_ready", in_ready, 1);
`endif
  endtask

  function automatic logic [7:0] rnd_byte();
    int r = $urandom_range(0, 99);
    return r < 55 ? 8'($urandom_range(32, 126)) : r < 63 ? 8'h0D : r < 74 ? 8'h0A :
           r < 81 ? 8'h08 : r < 88 ? 8'h09 : 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int n, w0;
    fork
      forever begin
        @(negedge pclk);
        if (!clr && buffer_wen) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data %0h with none expected", buffer_addr, buffer_din);
          end else begin
            e = q.pop_front();
            check("wr_addr", buffer_addr, e.a);
            check("wr_data", buffer_din, e.d);
          end
          prev_wr = last_wr;
          last_wr = cyc;
          wr_cnt++;
        end
      end
    join_none
    tick(1);
    do_reset();
    send(8'h41);
    send(8'h42);
    tick(2);
    check("ab_consecutive", last_wr - prev_wr, 1);
    check_cursor();
    check("ab_drained", q.size(), 0);

    do_reset();
    for (int i = 0; i < 81; i++) send(8'h61 + 8'(i % 26));
    tick(2);
    check("x_clamped", cursor_x, 79);
    check("row0_drained", q.size(), 0);

    do_reset();
    repeat (5) send(8'h0A);
    repeat (10) send(8'h78);
    tick(2);
    check_cursor();
    w0 = wr_cnt;
    send(8'h0D);
    send(8'h0A);
    send(8'h08);
    tick(2);
    check("ctrl_x", cursor_x, 0);
    check("ctrl_y", cursor_y, 6);
    check("ctrl_no_write", wr_cnt - w0, 0);

    do_reset();
    repeat (23) send(8'h0A);
    send(8'h0A);
    n = 0;
    while (!in_ready && n < 200) begin tick(1); n++; end
    check("clear_low_cycles", n, COLS);
    check_cursor();
    send(8'h5A);
    tick(2);
    check("scroll_drained", q.size(), 0);

    do_reset();
    repeat (46) send(8'h0A);
    wait_ready("wait_fr23");
    check("fr_23", first_row, 23);
    send(8'h0A);
    wait_ready("wait_wrap");
    tick(1);
    check("fr_wrap", first_row, 0);
    check("wrap_drained", q.size(), 0);

    do_reset();
    for (int i = 0; i < 1500; i++) begin
      send(rnd_byte());
      check_cursor();
      if ($urandom_range(0, 9) == 0) tick($urandom_range(1, 3));
    end
    wait_ready("final_idle");
    tick(2);
    check("final_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
